// File: rtl/sprite_animator.sv
// Sprite motion/animation controller: queues one command, applies it on new_frame, walks toward target.
// Optional SPRITE_ANIM_PINGPONG_EN: sheet index bounces 0..N-1..0 instead of wrapping.
module sprite_animator #(
    parameter int NUM_FRAMES      = 5,
    parameter int FRAMES_PER_STEP = 6,
    parameter int SPEED           = 2,
    parameter int H_ACTIVE        = 1280,
    parameter int V_ACTIVE        = 720
) (
    input  logic                          clk_pixel,
    input  logic                          sys_rst_n,
    input  logic                          new_frame,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [1:0]                    cmd_op,
    input  logic [10:0]                   cmd_x,
    input  logic [9:0]                    cmd_y,
    output logic                          sprite_valid,
    output logic [10:0]                   sprite_x,
    output logic [9:0]                    sprite_y,
    output logic [$clog2(NUM_FRAMES)-1:0] sprite_frame_number,
    output logic                          arrived
);
    localparam int FW = $clog2(NUM_FRAMES);
    localparam int DW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(NUM_FRAMES - 1);
    localparam logic [DW-1:0] DIV_LAST   = DW'(FRAMES_PER_STEP - 1);
    localparam logic [10:0]   X_MAX      = 11'(H_ACTIVE - 1);
    localparam logic [9:0]    Y_MAX      = 10'(V_ACTIVE - 1);
    localparam logic [10:0]   SPD_X      = 11'(SPEED);
    localparam logic [9:0]    SPD_Y      = 10'(SPEED);
    localparam logic [1:0]    OP_SPAWN   = 2'd0;
    localparam logic [1:0]    OP_MOVE    = 2'd1;
    localparam logic [1:0]    OP_DESPAWN = 2'd2;

    typedef enum logic [1:0] {IDLE, WALK, HOLD} state_t;

    state_t        state, n_state;
    logic          pend_v, n_pend_v;
    logic [1:0]    pend_op, n_pend_op;
    logic [10:0]   pend_x, n_pend_x, pos_x, n_pos_x, tgt_x, n_tgt_x;
    logic [9:0]    pend_y, n_pend_y, pos_y, n_pos_y, tgt_y, n_tgt_y;
    logic [DW-1:0] div, n_div, a_div;
    logic [FW-1:0] frame, n_frame, a_frame;
    logic          arr, n_arr;
`ifdef SPRITE_ANIM_PINGPONG_EN
    logic          dir_down, n_dir_down, a_dir_down;
`endif

    logic [10:0] dx, mx, step_x;
    logic [9:0]  dy, my, step_y;

    // Per-axis saturating step toward target; magnitude never exceeds the remaining distance.
    always_comb begin
        dx     = (pos_x < tgt_x) ? (tgt_x - pos_x) : (pos_x - tgt_x);
        mx     = (dx < SPD_X) ? dx : SPD_X;
        step_x = (pos_x < tgt_x) ? (pos_x + mx) : (pos_x - mx);
        dy     = (pos_y < tgt_y) ? (tgt_y - pos_y) : (pos_y - tgt_y);
        my     = (dy < SPD_Y) ? dy : SPD_Y;
        step_y = (pos_y < tgt_y) ? (pos_y + my) : (pos_y - my);
    end

    always_comb begin
        a_div   = div + DW'(1);
        a_frame = frame;
`ifdef SPRITE_ANIM_PINGPONG_EN
        a_dir_down = dir_down;
        if (div == DIV_LAST) begin
            a_div = '0;
            if (!dir_down) begin
                if (frame == FRAME_LAST) begin
                    a_frame    = frame - FW'(1);
                    a_dir_down = 1'b1;
                end else begin
                    a_frame = frame + FW'(1);
                end
            end else begin
                if (frame == '0) begin
                    a_frame    = FW'(1);
                    a_dir_down = 1'b0;
                end else begin
                    a_frame = frame - FW'(1);
                end
            end
        end
`else
        if (div == DIV_LAST) begin
            a_div   = '0;
            a_frame = (frame == FRAME_LAST) ? '0 : frame + FW'(1);
        end
`endif
    end

    always_comb begin
        n_state   = state;
        n_pend_v  = pend_v;
        n_pend_op = pend_op;
        n_pend_x  = pend_x;
        n_pend_y  = pend_y;
        n_pos_x   = pos_x;
        n_pos_y   = pos_y;
        n_tgt_x   = tgt_x;
        n_tgt_y   = tgt_y;
        n_div     = div;
        n_frame   = frame;
        n_arr     = 1'b0;
`ifdef SPRITE_ANIM_PINGPONG_EN
        n_dir_down = dir_down;
`endif
        if (new_frame)
            n_pend_v = 1'b0;
        // Accepting only while empty means an accept never collides with a drain.
        if (cmd_valid && !pend_v) begin
            n_pend_v  = 1'b1;
            n_pend_op = cmd_op;
            n_pend_x  = (cmd_x > X_MAX) ? X_MAX : cmd_x;
            n_pend_y  = (cmd_y > Y_MAX) ? Y_MAX : cmd_y;
        end
        if (new_frame) begin
            if (pend_v && pend_op == OP_SPAWN) begin
                n_state = HOLD;
                n_pos_x = pend_x;
                n_pos_y = pend_y;
                n_tgt_x = pend_x;
                n_tgt_y = pend_y;
                n_div   = '0;
                n_frame = '0;
`ifdef SPRITE_ANIM_PINGPONG_EN
                n_dir_down = 1'b0;
`endif
            end else if (pend_v && pend_op == OP_DESPAWN) begin
                n_state = IDLE;
                n_div   = '0;
                n_frame = '0;
`ifdef SPRITE_ANIM_PINGPONG_EN
                n_dir_down = 1'b0;
`endif
            end else if (state != IDLE) begin
                n_div   = a_div;
                n_frame = a_frame;
`ifdef SPRITE_ANIM_PINGPONG_EN
                n_dir_down = a_dir_down;
`endif
                if (pend_v && pend_op == OP_MOVE) begin
                    n_tgt_x = pend_x;
                    n_tgt_y = pend_y;
                    if (pend_x == pos_x && pend_y == pos_y) begin
                        n_state = HOLD;
                        n_arr   = 1'b1;
                    end else begin
                        n_state = WALK;
                    end
                end else if (state == WALK) begin
                    n_pos_x = step_x;
                    n_pos_y = step_y;
                    if (step_x == tgt_x && step_y == tgt_y) begin
                        n_state = HOLD;
                        n_arr   = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_pixel or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state   <= IDLE;
            pend_v  <= 1'b0;
            pend_op <= '0;
            pend_x  <= '0;
            pend_y  <= '0;
            pos_x   <= '0;
            pos_y   <= '0;
            tgt_x   <= '0;
            tgt_y   <= '0;
            div     <= '0;
            frame   <= '0;
            arr     <= 1'b0;
`ifdef SPRITE_ANIM_PINGPONG_EN
            dir_down <= 1'b0;
`endif
        end else begin
            state   <= n_state;
            pend_v  <= n_pend_v;
            pend_op <= n_pend_op;
            pend_x  <= n_pend_x;
            pend_y  <= n_pend_y;
            pos_x   <= n_pos_x;
            pos_y   <= n_pos_y;
            tgt_x   <= n_tgt_x;
            tgt_y   <= n_tgt_y;
            div     <= n_div;
            frame   <= n_frame;
            arr     <= n_arr;
`ifdef SPRITE_ANIM_PINGPONG_EN
            dir_down <= n_dir_down;
`endif
        end
    end

    assign cmd_ready           = !pend_v;
    assign sprite_valid        = (state != IDLE);
    assign sprite_x            = pos_x;
    assign sprite_y            = pos_y;
    assign sprite_frame_number = frame;
    assign arrived             = arr;
endmodule
